fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Write-side sequencer for the async FIFO memory, running in the write clock domain.
//  Shares the single FIFO write port between two requesters:
//   - src0: register-file read data, one word per request.
//   - src1: ALU result, 2*DATA_WIDTH wide, sent as two words (LSB word, then MSB word).
//  Round-robin arbitration; a src1 burst is atomic. Drives w_inc/w_data and honours w_full.
// PARAMETERS
//  DATA_WIDTH  8  FIFO word width.
//  CNT_WIDTH   8  Width of the committed-write counter.
// PORTS
//  w_clk    in   1             Write-domain clock; all logic on rising edge.
//  w_rst_n  in   1             Asynchronous, active-low reset.
//  arb_en   in   1             Enables new grants. An in-flight burst always completes.
//  req0     in   1             src0 request. Held with d0 stable until ack0.
//  d0       in   DATA_WIDTH    src0 data word.
//  ack0     out  1             1-cycle pulse: d0 captured.
//  req1     in   1             src1 request. Held with d1 stable until ack1.
//  d1       in   2*DATA_WIDTH  src1 result. [DATA_WIDTH-1:0] is sent first.
//  ack1     out  1             1-cycle pulse: full d1 captured.
//  w_full   in   1             FIFO full, already synchronised to the write domain.
//  w_inc    out  1             Registered write strobe to FIFO memory and write pointer.
//  w_data   out  DATA_WIDTH    Registered write data.
//  busy     out  1             High in HI state or while w_inc=1.
//  wr_cnt   out  CNT_WIDTH     Count of committed writes (w_inc & !w_full). Wraps at 2^CNT_WIDTH.
// BEHAVIOUR
//  Reset values: w_inc=0, w_data=0, ack0=0, ack1=0, wr_cnt=0, state=IDLE, last_gnt=1
//   (so src0 wins the first tie), msb_q=0.
//  Commit: a FIFO write occurs in any cycle with w_inc=1 and w_full=0.
//   If w_full=1, w_inc and w_data hold their values unchanged.
//  Slot free: slot_free = !w_inc | !w_full. All loads below happen only when slot_free=1.
//  State IDLE, slot free, arb_en=1:
//   - Only req0: w_data<=d0, w_inc<=1, ack0<=1, last_gnt<=0.
//   - Only req1: w_data<=d1[LSB word], msb_q<=d1[MSB word], w_inc<=1, ack1<=1,
//     last_gnt<=1, state->HI.
//   - Both: grant the source with !last_gnt.
//   - Neither, or arb_en=0: w_inc<=0.
//  State HI, slot free: w_data<=msb_q, w_inc<=1, state->IDLE.
//   - No ack is issued and req0 is ignored (the burst is atomic).
//   - arb_en is ignored in HI.
//  Slot not free (w_inc=1 & w_full=1): no grant, no ack, state unchanged.
//  Latency: req sampled high at edge N -> ack and w_inc high after edge N (1 cycle).
//   - Back-to-back single words sustain one write per cycle while !w_full.
//   - A src1 burst occupies 2 commit cycles.
//  Ack: a single pulse per grant. The requester may drop req or present new data the
//   cycle after ack. The same req is never acked twice.
//  wr_cnt increments on every commit, including a commit in the same cycle as a new load.
//  Asynchronous reset mid-burst: the pending MSB word is discarded, outputs return to
//   reset values immediately, and no partial-state recovery is attempted.
//  w_full rising while w_inc=1: the word is held until w_full falls, then commits exactly once.
// STRUCTURE
//  Shared package/header (fifo_pkg):
//   - State encodings ST_IDLE=1'b0, ST_HI=1'b1.
//   - Source IDs SRC0=1'b0, SRC1=1'b1.
//   - DATA_WIDTH default.
//  One sub-module, rr_arb2: combinational 2-way round-robin grant (req0, req1, last_gnt -> gnt0, gnt1).
//  FSM, output register, msb_q and wr_cnt stay in the top module.
// TESTING
//  1. Reset, then req0=1, d0=8'hA5, w_full=0
//     -> ack0 and w_inc pulse 1 cycle after, w_data=8'hA5, wr_cnt=1.
//  2. req1=1, d1=16'hBEEF, w_full=0
//     -> ack1 after 1 cycle; w_data=8'hEF then 8'hBE on consecutive cycles; wr_cnt+=2.
//  3. req0 and req1 held high from reset, d0=8'h11, d1=16'h3322
//     -> write order 11, 22, 33, 11, 22, 33 ...; src0 never writes between 22 and 33.
//  4. w_full=1 during the HI word 8'hBE for 5 cycles
//     -> w_inc=1 and w_data=8'hBE held, no ack, wr_cnt frozen; one commit after w_full falls.
//  5. arb_en=0 after ack1
//     -> MSB word still written, then w_inc=0, busy=0, no further acks while req0=1.
//  6. w_rst_n low in HI state
//     -> w_inc=0, w_data=0, wr_cnt=0 immediately; after release req0 is granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM states, source IDs
// and default widths.
package fifo_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HI   = 1'b1
    } state_e;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    localparam int DATA_WIDTH_DFLT = 8;
    localparam int CNT_WIDTH_DFLT  = 8;

endpackage : fifo_pkg

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and FIFO write-port bundle between the two requesters, the
// arbiter and the FIFO memory.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic                    arb_en;
    logic                    req0;
    logic [DATA_WIDTH-1:0]   d0;
    logic                    ack0;
    logic                    req1;
    logic [2*DATA_WIDTH-1:0] d1;
    logic                    ack1;
    logic                    w_full;
    logic                    w_inc;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    busy;
    logic [CNT_WIDTH-1:0]    wr_cnt;

    // Requesters plus FIFO status side
    modport master (
        output arb_en, req0, d0, req1, d1, w_full,
        input  ack0, ack1, w_inc, w_data, busy, wr_cnt
    );

    modport slave (
        input  arb_en, req0, d0, req1, d1, w_full,
        output ack0, ack1, w_inc, w_data, busy, wr_cnt
    );
endinterface : fifo_wr_arbiter_if

// File: rtl/fifo_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie, the source not granted last time wins.
module rr_arb2
    import fifo_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_gnt_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    always_comb begin
        gnt0_o = req0_i & (!req1_i || (last_gnt_i == SRC1));
        gnt1_o = req1_i & (!req0_i || (last_gnt_i == SRC0));
    end

endmodule : rr_arb2

// File: rtl/fifo_wr_arbiter.sv
// Write-domain sequencer sharing the FIFO write port between a single-word
// source and a two-word (LSB then MSB) atomic burst source.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int CNT_WIDTH  = CNT_WIDTH_DFLT
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    fifo_wr_arbiter_if.slave  bus
);

    state_e                state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic [DATA_WIDTH-1:0] msb_q, msb_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  w_inc_q, w_inc_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q;

    logic slot_free;
    logic commit;
    logic gnt0, gnt1;

    // A held word (w_inc & w_full) blocks every load until it commits
    assign slot_free = !w_inc_q || !bus.w_full;
    assign commit    = w_inc_q && !bus.w_full;

    rr_arb2 u_rr_arb2 (
        .req0_i     (bus.req0 & bus.arb_en),
        .req1_i     (bus.req1 & bus.arb_en),
        .last_gnt_i (last_gnt_q),
        .gnt0_o     (gnt0),
        .gnt1_o     (gnt1)
    );

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        msb_d      = msb_q;
        w_data_d   = w_data_q;
        w_inc_d    = w_inc_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;

        if (slot_free) begin
            unique case (state_q)
                ST_IDLE: begin
                    w_inc_d = 1'b0;
                    if (gnt0) begin
                        w_data_d   = bus.d0;
                        w_inc_d    = 1'b1;
                        ack0_d     = 1'b1;
                        last_gnt_d = SRC0;
                    end else if (gnt1) begin
                        w_data_d   = bus.d1[DATA_WIDTH-1:0];
                        msb_d      = bus.d1[2*DATA_WIDTH-1:DATA_WIDTH];
                        w_inc_d    = 1'b1;
                        ack1_d     = 1'b1;
                        last_gnt_d = SRC1;
                        state_d    = ST_HI;
                    end
                end
                // Burst tail: no arbitration, arb_en and req0 are ignored
                ST_HI: begin
                    w_data_d = msb_q;
                    w_inc_d  = 1'b1;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= SRC1;
            msb_q      <= '0;
            w_data_q   <= '0;
            w_inc_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            msb_q      <= msb_d;
            w_data_q   <= w_data_d;
            w_inc_q    <= w_inc_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            wr_cnt_q   <= wr_cnt_q + CNT_WIDTH'(commit);
        end
    end

    assign bus.w_inc  = w_inc_q;
    assign bus.w_data = w_data_q;
    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.busy   = (state_q == ST_HI) || w_inc_q;
    assign bus.wr_cnt = wr_cnt_q;

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed multi-cycle sequences and
// random traffic against a queue-based reference model.
module tb_fifo_wr_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic w_clk;
    logic w_rst_n;

    fifo_wr_arbiter_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .bus     (bus)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    typedef struct {
        logic        en;
        logic        r0;
        logic [7:0]  d0;
        logic        r1;
        logic [15:0] d1;
        logic        full;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl [16];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    // Reference model state
    logic       m_inc, m_ack0, m_ack1, m_pref;
    logic [7:0] m_data, m_cnt;
    logic [7:0] mq [$];

    function automatic logic [19:0] ex(input logic a0, input logic a1, input logic inc,
                                       input logic [7:0] data, input logic busy,
                                       input logic [7:0] cnt);
        return {a0, a1, inc, data, busy, cnt};
    endfunction

    function automatic logic [19:0] obs();
        return {bus.ack0, bus.ack1, bus.w_inc, bus.w_data, bus.busy, bus.wr_cnt};
    endfunction

    task automatic chk(input string nm, input logic [19:0] got, input logic [19:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got={a0,a1,inc,data,busy,cnt}=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic r0, input logic [7:0] d0,
                         input logic r1, input logic [15:0] d1, input logic full);
        bus.arb_en = en;
        bus.req0   = r0;
        bus.d0     = d0;
        bus.req1   = r1;
        bus.d1     = d1;
        bus.w_full = full;
    endtask

    task automatic model_reset();
        m_inc  = 1'b0;
        m_ack0 = 1'b0;
        m_ack1 = 1'b0;
        m_pref = 1'b0;
        m_data = 8'h00;
        m_cnt  = 8'h00;
        mq.delete();
    endtask

    // Predict outputs after the coming edge from the inputs currently driven
    task automatic model_step();
        logic commit;
        logic pick1;
        commit = m_inc && !bus.w_full;
        m_ack0 = 1'b0;
        m_ack1 = 1'b0;
        if (!(m_inc && bus.w_full)) begin
            if (mq.size() != 0) begin
                m_data = mq.pop_front();
                m_inc  = 1'b1;
            end else if (bus.arb_en && (bus.req0 || bus.req1)) begin
                pick1 = bus.req1 && (!bus.req0 || m_pref);
                if (pick1) begin
                    m_data = bus.d1[7:0];
                    mq.push_back(bus.d1[15:8]);
                    m_ack1 = 1'b1;
                    m_pref = 1'b0;
                end else begin
                    m_data = bus.d0;
                    m_ack0 = 1'b1;
                    m_pref = 1'b1;
                end
                m_inc = 1'b1;
            end else begin
                m_inc = 1'b0;
            end
        end
        m_cnt = m_cnt + {7'd0, commit};
    endtask

    function automatic logic [19:0] model_exp();
        return {m_ack0, m_ack1, m_inc, m_data, (m_inc || mq.size() != 0), m_cnt};
    endfunction

    initial begin
        logic [7:0] seq3 [3];
        logic [7:0] exp_d;
        logic       ea0, ea1;

        tbl[0]  = '{H, H, 8'hA5, L, 16'h0000, L, ex(H, L, H, 8'hA5, H, 8'd0)};
        tbl[1]  = '{H, L, 8'h00, H, 16'hBEEF, L, ex(L, H, H, 8'hEF, H, 8'd1)};
        tbl[2]  = '{H, L, 8'h00, L, 16'h0000, L, ex(L, L, H, 8'hBE, H, 8'd2)};
        for (int i = 3; i < 8; i++)
            tbl[i] = '{H, H, 8'h77, L, 16'h0000, H, ex(L, L, H, 8'hBE, H, 8'd2)};
        tbl[8]  = '{H, H, 8'h77, L, 16'h0000, L, ex(H, L, H, 8'h77, H, 8'd3)};
        tbl[9]  = '{H, L, 8'h00, L, 16'h0000, L, ex(L, L, L, 8'h77, L, 8'd4)};
        tbl[10] = '{H, L, 8'h00, H, 16'h1234, H, ex(L, H, H, 8'h34, H, 8'd4)};
        tbl[11] = '{H, L, 8'h00, L, 16'h0000, H, ex(L, L, H, 8'h34, H, 8'd4)};
        tbl[12] = '{H, L, 8'h00, L, 16'h0000, L, ex(L, L, H, 8'h12, H, 8'd5)};
        tbl[13] = '{L, H, 8'h55, L, 16'h0000, L, ex(L, L, L, 8'h12, L, 8'd6)};
        tbl[14] = '{L, H, 8'h55, L, 16'h0000, L, ex(L, L, L, 8'h12, L, 8'd6)};
        tbl[15] = '{H, H, 8'h55, L, 16'h0000, L, ex(H, L, H, 8'h55, H, 8'd6)};

        drive(L, L, 8'h00, L, 16'h0000, L);
        w_rst_n = 1'b0;
        repeat (2) @(negedge w_clk);
        chk("reset_state", obs(), ex(L, L, L, 8'h00, L, 8'd0));

        // Table: inputs at negedge, outputs checked one edge later
        w_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].en, tbl[i].r0, tbl[i].d0, tbl[i].r1, tbl[i].d1, tbl[i].full);
            @(negedge w_clk);
            chk($sformatf("table_%0d", i), obs(), tbl[i].exp);
        end

        // Both sources held: 11,22,33 repeating, never 11 between 22 and 33
        w_rst_n = 1'b0;
        drive(H, H, 8'h11, H, 16'h3322, L);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        seq3[0] = 8'h11;
        seq3[1] = 8'h22;
        seq3[2] = 8'h33;
        for (int k = 0; k < 9; k++) begin
            @(negedge w_clk);
            exp_d = seq3[k % 3];
            ea0   = (k % 3 == 0);
            ea1   = (k % 3 == 1);
            chk($sformatf("rr_order_%0d", k), obs(), ex(ea0, ea1, H, exp_d, H, 8'(k)));
        end

        // arb_en dropped after ack1: MSB still written, then idle
        drive(H, L, 8'h00, H, 16'hA1B2, L);
        @(negedge w_clk);
        chk("en_off_ack1", obs(), ex(L, H, H, 8'hB2, H, 8'd9));
        drive(L, H, 8'h66, L, 16'h0000, L);
        @(negedge w_clk);
        chk("en_off_msb", obs(), ex(L, L, H, 8'hA1, H, 8'd10));
        for (int k = 0; k < 4; k++) begin
            @(negedge w_clk);
            chk($sformatf("en_off_idle_%0d", k), obs(), ex(L, L, L, 8'hA1, L, 8'd11));
        end

        // Reset asserted while the MSB word is pending
        drive(H, L, 8'h00, H, 16'hCDEF, L);
        @(negedge w_clk);
        chk("hi_before_rst", obs(), ex(L, H, H, 8'hEF, H, 8'd11));
        drive(H, H, 8'h5A, H, 16'h7788, L);
        #2 w_rst_n = 1'b0;
        #1 chk("rst_async", obs(), ex(L, L, L, 8'h00, L, 8'd0));
        @(negedge w_clk);
        w_rst_n = 1'b1;
        @(negedge w_clk);
        chk("rst_src0_first", obs(), ex(H, L, H, 8'h5A, H, 8'd0));

        // Random traffic against the reference model
        drive(L, L, 8'h00, L, 16'h0000, L);
        w_rst_n = 1'b0;
        @(negedge w_clk);
        w_rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 800; c++) begin
            chk($sformatf("rand_%0d", c), obs(), model_exp());
            if (m_ack0) bus.req0 = 1'b0;
            if (m_ack1) bus.req1 = 1'b0;
            if (!bus.req0 && $urandom_range(0, 1) == 1) begin
                bus.req0 = 1'b1;
                bus.d0   = 8'($urandom);
            end
            if (!bus.req1 && $urandom_range(0, 1) == 1) begin
                bus.req1 = 1'b1;
                bus.d1   = 16'($urandom);
            end
            bus.arb_en = ($urandom_range(0, 7) != 0);
            bus.w_full = ($urandom_range(0, 3) == 0);
            model_step();
            @(negedge w_clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
